fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Parametrised instruction-fetch front end that replaces the bare PC register, +4 adder and branch mux of the single-cycle datapath. It holds the fetch PC and issues requests to a 1-cycle-latency instruction memory. Returned words are buffered, tagged with their PC, in a QDEPTH-entry queue. Decode drains the queue through a valid/ready handshake, and a branch redirect flushes all wrong-path work.

Parameters:
ADDR_W, 64, PC / address width in bits
INSTR_W, 32, instruction word width
RESET_PC, 0, fetch PC loaded on reset
INCR, 4, sequential PC increment; must be a power of two
QDEPTH, 4, fetch queue entries; must be a power of two and >= 2

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  fetch request this cycle
imem_addr  out  ADDR_W  fetch address (= fpc)
imem_rdata  in  INSTR_W  word for the request issued in the previous cycle
br_valid  in  1  redirect request, single-cycle pulse
br_mode  in  1  0: target = br_pc + br_offset; 1: target = br_offset
br_pc  in  ADDR_W  PC of the branch instruction
br_offset  in  ADDR_W  two's-complement byte offset, or absolute target
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  INSTR_W  head instruction
out_pc  out  ADDR_W  PC of head instruction
q_count  out  $clog2(QDEPTH+1)  entries currently in queue

Behaviour:
- State: fpc, queue storage with rd/wr pointers and count, inflight flag, inflight_pc.
- Reset (at the edge where reset=1): fpc=RESET_PC, count=0, inflight=0, pointers=0. While reset=1: imem_req=0, out_valid=0, q_count=0. Reset dominates every other input, including mid-redirect and mid-fetch.
- Issue: imem_req = !reset && !br_valid && (count + inflight < QDEPTH). This is credit-based, so the queue never overflows.
- On issue: inflight<=1, inflight_pc<=fpc, fpc<=fpc+INCR modulo 2^ADDR_W. 0xFFFF_FFFF_FFFF_FFFC wraps to 0 with no flag.
- If no request issues: inflight<=0 and fpc holds.
- Response: when inflight=1 and no redirect this cycle, {imem_rdata, inflight_pc} is written at the queue tail at the end of the cycle.
- Latency: request in cycle t, out_valid=1 in cycle t+2. There is no bypass path.
- Pop: occurs on out_valid && out_ready. The head is removed at the edge. Push and pop in the same cycle leave count unchanged.
- Throughput: with out_ready held high and QDEPTH >= 3, the block sustains one instruction per cycle after the 2-cycle fill.
- Head outputs are taken straight from queue storage at rd pointer. out_instr and out_pc are don't-care when out_valid=0.
- Redirect (br_valid=1 in cycle t):
  - target is computed per br_mode, with low log2(INCR) bits forced to 0; ADDR_W-bit wrap applies.
  - At the edge: fpc<=target, count<=0, pointers reset, inflight<=0. Any response due in t is discarded.
  - No request issues in t. The first request is to target in t+1, and out_valid rises in t+3.
  - A pop handshake completing in cycle t is honoured: decode keeps that instruction; all other entries are discarded.
- Simultaneous events: redirect overrides push and issue; reset overrides redirect.
- out_ready=0 with the queue full: imem_req stays 0, fpc stays unchanged, and queue contents are stable.
- q_count equals count and is updated at the edge.

Test Plan:
1. Reset, then out_ready=1, RESET_PC=0x1000 -> imem_addr sequence 0x1000, 0x1004, 0x1008…; out_valid first high 2 cycles after the first req, out_pc tracks with one instruction per cycle, q_count <= 2.
2. out_ready=0 for 10 cycles -> exactly QDEPTH=4 requests issue (0x1000–0x100C), q_count=4, imem_req=0, fpc=0x1010 stable. Then out_ready=1 -> 4 pops in PC order, fetching resumes at 0x1010.
3. Queue holds 3 entries, br_valid with br_mode=0, br_pc=0x1008, br_offset=-8 -> imem_req=0 that cycle, q_count=0 next cycle, next imem_addr=0x1000, the stale inflight word never appears at out_pc.
4. br_mode=1, br_offset=0x2003, with a pop handshake in the same cycle -> popped entry delivered, fetch restarts at 0x2000 (alignment), first out_pc=0x2000 three cycles later.
5. fpc=0xFFFF_FFFF_FFFF_FFF8, free-running -> addresses ...FFF8, ...FFFC, 0x0, 0x4, tags matching.
6. Reset asserted while the queue is full and a request is inflight -> all outputs at reset values next cycle; after release the first imem_addr is RESET_PC and no pre-reset word is ever output.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: holds the fetch PC, issues one request per cycle
// to a 1-cycle-latency instruction memory and buffers tagged words for decode.
module fetch_unit #(
    parameter int                  ADDR_W   = 64,
    parameter int                  INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int                  INCR     = 4,
    parameter int                  QDEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          imem_req,
    output logic [ADDR_W-1:0]             imem_addr,
    input  logic [INSTR_W-1:0]            imem_rdata,
    input  logic                          br_valid,
    input  logic                          br_mode,
    input  logic [ADDR_W-1:0]             br_pc,
    input  logic [ADDR_W-1:0]             br_offset,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INSTR_W-1:0]            out_instr,
    output logic [ADDR_W-1:0]             out_pc,
    output logic [$clog2(QDEPTH+1)-1:0]   q_count
);

    localparam int                CNT_W      = $clog2(QDEPTH + 1);
    localparam int                PTR_W      = $clog2(QDEPTH);
    localparam logic [ADDR_W-1:0] INCR_A     = ADDR_W'(INCR);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INCR) - ADDR_W'(1));

    logic [ADDR_W-1:0]  fpc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [ADDR_W-1:0]  target;

    logic [INSTR_W-1:0] instr_mem [QDEPTH];
    logic [ADDR_W-1:0]  pc_mem    [QDEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               credit_ok;
    logic               issue;
    logic               push;
    logic               pop;

    // A request only issues when the queue has room for every word already in flight.
    assign credit_ok = ({1'b0, count} + (CNT_W+1)'(inflight)) < (CNT_W+1)'(QDEPTH);
    assign issue     = !reset && !br_valid && credit_ok;
    assign push      = !reset && !br_valid && inflight;

    // Decode handshake: the head transfers on any cycle where out_valid and
    // out_ready are both high; out_valid never depends on out_ready, and the
    // head stays stable while out_valid is high and out_ready is low.
    assign out_valid = !reset && (count != '0);
    assign pop       = out_valid && out_ready;

    assign imem_req  = issue;
    assign imem_addr = fpc;
    assign out_instr = instr_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];
    assign q_count   = reset ? '0 : count;

    assign target = (br_mode ? br_offset : (br_pc + br_offset)) & ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc         <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (br_valid) begin
            // A redirect drops the queue and the word returning this cycle.
            fpc      <= target;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fpc;
                fpc         <= fpc + INCR_A;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a
// queue-based reference model of the fetch stream.
module tb_fetch_unit;

    localparam int          QDEPTH   = 4;
    localparam int          INCR     = 4;
    localparam logic [63:0] RESET_PC = 64'h1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        br_valid = 1'b0;
    logic        br_mode = 1'b0;
    logic [63:0] br_pc = '0;
    logic [63:0] br_offset = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  q_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] key;

    // reference model: fetch PC, the word in flight and the queued PCs
    logic [63:0] m_fpc;
    logic        m_inflight;
    logic [63:0] m_ipc;
    logic [63:0] exp_q[$];

    fetch_unit #(
        .ADDR_W(64), .INSTR_W(32), .RESET_PC(RESET_PC), .INCR(INCR), .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .br_valid(br_valid), .br_mode(br_mode), .br_pc(br_pc), .br_offset(br_offset),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .q_count(q_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [63:0] pc);
        return {pc[15:0], pc[31:16]} ^ pc[63:32] ^ key;
    endfunction

    // instruction memory: answers the previous cycle's request, garbage otherwise
    always @(posedge clk) begin
        imem_rdata <= imem_req ? word_of(imem_addr) : 32'($urandom);
    end

    function automatic logic m_req();
        return !reset && !br_valid && (exp_q.size() + int'(m_inflight) < QDEPTH);
    endfunction

    task automatic model_update();
        logic req_now;
        logic pop_now;
        req_now = m_req();
        pop_now = !reset && exp_q.size() != 0 && out_ready;
        if (reset) begin
            m_fpc = RESET_PC;
            m_inflight = 1'b0;
            exp_q.delete();
        end else if (br_valid) begin
            m_fpc = (br_mode ? br_offset : br_pc + br_offset) & ~(64'(INCR) - 64'd1);
            m_inflight = 1'b0;
            exp_q.delete();
        end else begin
            if (pop_now) void'(exp_q.pop_front());
            if (m_inflight) exp_q.push_back(m_ipc);
            if (req_now) begin
                m_ipc = m_fpc;
                m_fpc = m_fpc + 64'(INCR);
            end
            m_inflight = req_now;
        end
    endtask

    // advance one cycle, then apply this cycle's inputs; outputs settle by return
    task automatic drive(input logic rst, input logic br, input logic mode,
                         input logic [63:0] bpc, input logic [63:0] boff, input logic rdy);
        @(posedge clk);
        model_update();
        @(negedge clk);
        reset = rst; br_valid = br; br_mode = mode; br_pc = bpc; br_offset = boff; out_ready = rdy;
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 1'b0, '0, '0, rdy);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
            checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", q_count); end
        end
        idle(1'b1);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL first_addr: got %h expected %h", imem_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        logic [63:0] e;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            idle(1'b1);
            e = RESET_PC + 64'(4 * i);
            checks++; if (imem_req !== 1'b1 || imem_addr !== e) begin errors++; $display("FAIL stream_addr: got %b/%h expected 1/%h", imem_req, imem_addr, e); end
            checks++; if (out_valid !== (i >= 2)) begin errors++; $display("FAIL stream_valid: cycle %0d got %b expected %b", i, out_valid, i >= 2); end
            if (i >= 2) begin
                e = RESET_PC + 64'(4 * (i - 2));
                checks++; if (out_pc !== e || out_instr !== word_of(e)) begin errors++; $display("FAIL stream_head: got %h/%h expected %h/%h", out_pc, out_instr, e, word_of(e)); end
            end
            checks++; if (q_count !== ((i >= 2) ? 3'd1 : 3'd0)) begin errors++; $display("FAIL stream_count: cycle %0d got %0d", i, q_count); end
        end
    endtask

    task automatic test_full();
        int nreq;
        logic [63:0] e;
        do_reset();
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            if (imem_req) begin
                e = RESET_PC + 64'(4 * nreq);
                checks++; if (imem_addr !== e) begin errors++; $display("FAIL full_addr: got %h expected %h", imem_addr, e); end
                nreq++;
            end
        end
        checks++; if (nreq !== 4) begin errors++; $display("FAIL full_nreq: got %0d expected 4", nreq); end
        checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", q_count); end
        checks++; if (imem_req !== 1'b0 || imem_addr !== 64'h1010) begin errors++; $display("FAIL full_hold: got %b/%h expected 0/1010", imem_req, imem_addr); end
        checks++; if (out_pc !== RESET_PC || out_instr !== word_of(RESET_PC)) begin errors++; $display("FAIL full_head: got %h/%h expected %h", out_pc, out_instr, RESET_PC); end
        for (int j = 0; j < 5; j++) begin
            idle(1'b1);
            e = RESET_PC + 64'(4 * j);
            checks++; if (out_valid !== 1'b1 || out_pc !== e || out_instr !== word_of(e)) begin errors++; $display("FAIL drain_head: got %b/%h expected 1/%h", out_valid, out_pc, e); end
            if (j == 0) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_req0: got %b expected 0", imem_req); end
            end
            if (j == 1) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h1010) begin errors++; $display("FAIL drain_resume: got %b/%h expected 1/1010", imem_req, imem_addr); end
            end
        end
    endtask

    task automatic test_redirect_rel();
        do_reset();
        for (int i = 0; i < 4; i++) idle(1'b0);
        drive(1'b0, 1'b1, 1'b0, 64'h1008, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        checks++; if (q_count !== 3'd3) begin errors++; $display("FAIL rel_pre_count: got %0d expected 3", q_count); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rel_req: got %b expected 0", imem_req); end
        idle(1'b1);
        checks++; if (q_count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rel_flush: got %0d/%b expected 0/0", q_count, out_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h1000) begin errors++; $display("FAIL rel_target: got %b/%h expected 1/1000", imem_req, imem_addr); end
        idle(1'b1);
        checks++; if (out_valid !== 1'b0 || imem_addr !== 64'h1004) begin errors++; $display("FAIL rel_t2: got %b/%h expected 0/1004", out_valid, imem_addr); end
        idle(1'b1);
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h1000 || out_instr !== word_of(64'h1000)) begin errors++; $display("FAIL rel_first: got %b/%h expected 1/1000", out_valid, out_pc); end
        idle(1'b1);
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h1004) begin errors++; $display("FAIL rel_second: got %b/%h expected 1/1004", out_valid, out_pc); end
    endtask

    task automatic test_redirect_abs();
        do_reset();
        for (int i = 0; i < 3; i++) idle(1'b1);
        drive(1'b0, 1'b1, 1'b1, {$urandom, $urandom}, 64'h2003, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h1004 || out_instr !== word_of(64'h1004)) begin errors++; $display("FAIL abs_pop: got %b/%h expected 1/1004", out_valid, out_pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL abs_req: got %b expected 0", imem_req); end
        idle(1'b1);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h2000 || q_count !== 3'd0) begin errors++; $display("FAIL abs_target: got %b/%h/%0d expected 1/2000/0", imem_req, imem_addr, q_count); end
        idle(1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abs_early: got %b expected 0", out_valid); end
        idle(1'b1);
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h2000 || out_instr !== word_of(64'h2000)) begin errors++; $display("FAIL abs_first: got %b/%h expected 1/2000", out_valid, out_pc); end
    endtask

    task automatic test_wrap();
        logic [63:0] base;
        logic [63:0] e;
        base = 64'hFFFF_FFFF_FFFF_FFF8;
        do_reset();
        drive(1'b0, 1'b1, 1'b1, '0, base, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            idle(1'b1);
            if (k <= 4) begin
                e = base + 64'(4 * (k - 1));
                checks++; if (imem_req !== 1'b1 || imem_addr !== e) begin errors++; $display("FAIL wrap_addr: got %b/%h expected 1/%h", imem_req, imem_addr, e); end
            end
            if (k >= 3) begin
                e = base + 64'(4 * (k - 3));
                checks++; if (out_valid !== 1'b1 || out_pc !== e || out_instr !== word_of(e)) begin errors++; $display("FAIL wrap_head: got %b/%h expected 1/%h", out_valid, out_pc, e); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) idle(1'b0);
        drive(1'b1, 1'b1, 1'b1, '0, 64'h3000, 1'b1);
        checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0 || q_count !== 3'd0) begin errors++; $display("FAIL mid_reset: got %b/%b/%0d expected 0/0/0", imem_req, out_valid, q_count); end
        idle(1'b1);
        checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC || q_count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_restart: got %b/%h/%0d expected 1/%h/0", imem_req, imem_addr, q_count, RESET_PC); end
        idle(1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale: got %b expected 0", out_valid); end
        idle(1'b1);
        checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_instr !== word_of(RESET_PC)) begin errors++; $display("FAIL mid_first: got %b/%h expected 1/%h", out_valid, out_pc, RESET_PC); end
    endtask

    task automatic test_random();
        logic       ev;
        logic [2:0] ecnt;
        logic [63:0] off;
        for (int i = 0; i < 600; i++) begin
            off = ($urandom_range(0, 1) == 1) ? 64'($signed($urandom_range(0, 128)) - 64) : {$urandom, $urandom};
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, off, ($urandom_range(0, 3) != 0));
            ev = !reset && exp_q.size() != 0;
            ecnt = reset ? 3'd0 : 3'(exp_q.size());
            checks++; if (imem_req !== m_req()) begin errors++; $display("FAIL rnd_req: cycle %0d got %b expected %b", i, imem_req, m_req()); end
            if (!reset) begin
                checks++; if (imem_addr !== m_fpc) begin errors++; $display("FAIL rnd_addr: cycle %0d got %h expected %h", i, imem_addr, m_fpc); end
            end
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL rnd_valid: cycle %0d got %b expected %b", i, out_valid, ev); end
            if (ev) begin
                checks++; if (out_pc !== exp_q[0] || out_instr !== word_of(exp_q[0])) begin errors++; $display("FAIL rnd_head: cycle %0d got %h/%h expected %h/%h", i, out_pc, out_instr, exp_q[0], word_of(exp_q[0])); end
            end
            checks++; if (q_count !== ecnt) begin errors++; $display("FAIL rnd_count: cycle %0d got %0d expected %0d", i, q_count, ecnt); end
        end
    endtask

    initial begin
        key = $urandom;
        test_reset();
        test_stream();
        test_full();
        test_redirect_rel();
        test_redirect_abs();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
